// File: rtl/cci_mpf_csrs_pkg.sv
// Shared definitions for the MPF CSR event counters.
//
// Contents:
//   t_csr_evt_idx         bit position of each event in evt_in / counter index
//   CSR_EVT_N             number of defined events
//   CSR_EVT_CTR_WIDTH     default counter width
//   CSR_EVT_IDX_W         width of the MMIO counter index
//   CSR_TID_W             width of the MMIO transaction ID
//   CSR_RSP_DATA_W        width of the read response data
//   csr_evt_idx_in_range  true when an index addresses an implemented counter

package cci_mpf_csrs_pkg;

    typedef enum logic [3:0] {
        CSR_EVT_4KB_HIT            = 4'd0,
        CSR_EVT_4KB_MISS           = 4'd1,
        CSR_EVT_2MB_HIT            = 4'd2,
        CSR_EVT_2MB_MISS           = 4'd3,
        CSR_EVT_PT_WALK_BUSY       = 4'd4,
        CSR_EVT_FAILED_TRANSLATION = 4'd5,
        CSR_EVT_VC_MAP_CHANGED     = 4'd6,
        CSR_EVT_WRO_RR_CONFLICT    = 4'd7,
        CSR_EVT_WRO_RW_CONFLICT    = 4'd8,
        CSR_EVT_WRO_WR_CONFLICT    = 4'd9,
        CSR_EVT_WRO_WW_CONFLICT    = 4'd10
    } t_csr_evt_idx;

    localparam int CSR_EVT_N         = 11;
    localparam int CSR_EVT_CTR_WIDTH = 48;
    localparam int CSR_EVT_IDX_W     = 4;
    localparam int CSR_TID_W         = 9;
    localparam int CSR_RSP_DATA_W    = 64;

    function automatic logic csr_evt_idx_in_range(
        input logic [CSR_EVT_IDX_W-1:0] idx,
        input int                       n_events
    );
        return int'(idx) < n_events;
    endfunction

endpackage

// File: rtl/cci_mpf_csr_event_ctr.sv
// Single free-running event counter.
//
// Ports:
//   clk    clock, all logic on the rising edge
//   reset  synchronous active-high reset, zeroes the counter
//   inc    add one this cycle (level inputs therefore count busy cycles)
//   clr    load the counter with the current inc bit instead of adding,
//          so an event coincident with a clear is kept
//   value  current count; wraps modulo 2^CTR_WIDTH, no saturation

module cci_mpf_csr_event_ctr #(
    parameter int CTR_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CTR_WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= CTR_WIDTH'(inc);
        end else if (inc) begin
            value <= value + CTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cci_mpf_csr_event_ctrs.sv
// Bank of MPF event counters with a two-stage MMIO read pipeline.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   reset         synchronous active-high reset
//   evt_in        per-cycle event strobes, bit i is t_csr_evt_idx value i
//   rd_req_valid  counter read request (accepted every cycle)
//   rd_req_idx    counter to read; out-of-range indices return 0
//   rd_req_tid    transaction ID echoed on the response
//   rd_req_clr    clear the addressed counter after sampling it
//   clr_all       clear every counter
//   rd_rsp_valid  one-cycle response strobe, two cycles after the request
//   rd_rsp_tid    echoed transaction ID (held while rd_rsp_valid is low)
//   rd_rsp_data   counter value zero-extended (held while rd_rsp_valid is low)
//
// Handshake: requests are valid-only. There is no ready; the block accepts a
// request on every cycle rd_req_valid is high, and rd_req_idx/tid/clr are
// don't-care when it is low. Responses are likewise valid-only with no
// backpressure and come back in request order with fixed latency.
//
// The sampled value is the counter contents before this cycle's update, so a
// read-with-clear or a clr_all in the same cycle returns the pre-clear count.
// N_EVENTS must not exceed 2^CSR_EVT_IDX_W.

module cci_mpf_csr_event_ctrs
    import cci_mpf_csrs_pkg::*;
#(
    parameter int N_EVENTS  = CSR_EVT_N,
    parameter int CTR_WIDTH = CSR_EVT_CTR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [N_EVENTS-1:0]       evt_in,

    input  logic                      rd_req_valid,
    input  logic [CSR_EVT_IDX_W-1:0]  rd_req_idx,
    input  logic [CSR_TID_W-1:0]      rd_req_tid,
    input  logic                      rd_req_clr,
    input  logic                      clr_all,

    output logic                      rd_rsp_valid,
    output logic [CSR_TID_W-1:0]      rd_rsp_tid,
    output logic [CSR_RSP_DATA_W-1:0] rd_rsp_data
);

    logic [CTR_WIDTH-1:0] ctr_value [N_EVENTS];
    logic [N_EVENTS-1:0]  ctr_clr;
    logic [CTR_WIDTH-1:0] sel_value;

    // Per-counter clear: global clear, or a valid read-with-clear aimed at
    // this counter. An out-of-range index matches no counter.
    always_comb begin
        ctr_clr = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            ctr_clr[i] = clr_all |
                         (rd_req_valid & rd_req_clr &
                          (rd_req_idx == CSR_EVT_IDX_W'(i)));
        end
    end

    for (genvar g = 0; g < N_EVENTS; g++) begin : gen_ctr
        cci_mpf_csr_event_ctr #(
            .CTR_WIDTH (CTR_WIDTH)
        ) u_ctr (
            .clk   (clk),
            .reset (reset),
            .inc   (evt_in[g]),
            .clr   (ctr_clr[g]),
            .value (ctr_value[g])
        );
    end

    // Read mux; indices with no counter fall through to zero.
    always_comb begin
        sel_value = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            if (rd_req_idx == CSR_EVT_IDX_W'(i)) begin
                sel_value = ctr_value[i];
            end
        end
    end

    // Stage 1: capture the request and the pre-update counter value.
    logic                      s1_valid;
    logic [CSR_EVT_IDX_W-1:0]  s1_idx;
    logic [CSR_TID_W-1:0]      s1_tid;
    logic [CSR_RSP_DATA_W-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_tid   <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_req_valid;
            if (rd_req_valid) begin
                s1_idx  <= rd_req_idx;
                s1_tid  <= rd_req_tid;
                s1_data <= CSR_RSP_DATA_W'(sel_value);
            end
        end
    end

    // Stage 2: response registers. Data and tid only move on a valid
    // response so the last value stays visible between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_tid   <= '0;
            rd_rsp_data  <= '0;
        end else begin
            rd_rsp_valid <= s1_valid;
            if (s1_valid) begin
                rd_rsp_tid  <= s1_tid;
                rd_rsp_data <= csr_evt_idx_in_range(s1_idx, N_EVENTS) ?
                               s1_data : '0;
            end
        end
    end

endmodule

// File: doc/cci_mpf_csr_event_ctrs.md
CCI_MPF_CSR_EVENT_CTRS -- requirements
Module: cci_mpf_csr_event_ctrs

Interface
REQ-001 Parameter N_EVENTS, default 11, number of event inputs and counters.
REQ-002 Parameter CTR_WIDTH, default 48, counter width in bits.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 evt_in  input  N_EVENTS  per-cycle event strobes, bit order per package index enum.
REQ-006 rd_req_valid  input  1  MMIO counter read request; no backpressure.
REQ-007 rd_req_idx  input  4  counter index to read.
REQ-008 rd_req_tid  input  9  MMIO transaction ID, returned with data.
REQ-009 rd_req_clr  input  1  clear the read counter after sampling.
REQ-010 clr_all  input  1  clear every counter.
REQ-011 rd_rsp_valid  output  1  read response strobe.
REQ-012 rd_rsp_tid  output  9  echoed tid.
REQ-013 rd_rsp_data  output  64  counter value, zero-extended.

Function
REQ-014 Each counter SHALL add 1 in every cycle its evt_in bit is high; level inputs (pt_walk_busy) SHALL therefore count busy cycles.
REQ-015 Counters SHALL wrap modulo 2^CTR_WIDTH; no saturation and no overflow flag.
REQ-016 Read pipeline SHALL be two stages: stage 1 registers idx, tid and the selected counter value; stage 2 drives the rd_rsp_* registers.
REQ-017 rd_rsp_valid SHALL assert exactly 2 cycles after the rd_req_valid cycle, for one cycle per request.
REQ-018 A read request SHALL be accepted in every cycle; back-to-back reads SHALL produce back-to-back responses in order.
REQ-019 Sampled value SHALL be the counter contents before that cycle's increment.
REQ-020 rd_req_idx >= N_EVENTS SHALL return data 0 with valid tid and SHALL NOT clear anything.
REQ-021 rd_req_clr with valid idx SHALL set the counter to evt_in[idx] (0 or 1) next cycle, so a simultaneous event is not lost.
REQ-022 clr_all SHALL set every counter to its same-cycle evt_in bit; clr_all concurrent with a read returns the pre-clear value.
REQ-023 rd_rsp_tid and rd_rsp_data SHALL hold their last values when rd_rsp_valid is low.
REQ-024 rd_req_clr or rd_req_idx with rd_req_valid low SHALL be ignored.

Reset
REQ-025 reset SHALL zero all counters, both pipeline valid bits, rd_rsp_valid, rd_rsp_tid and rd_rsp_data.
REQ-026 A request in flight when reset asserts SHALL be dropped; no response SHALL appear after reset.
REQ-027 evt_in and requests during reset SHALL be ignored; counting resumes the first cycle reset is low.

Structure
REQ-028 cci_mpf_csrs_pkg SHALL hold the event index enum (4KB hit, 4KB miss, 2MB hit, 2MB miss, PT walk busy, failed translation, VC mapping changed, WRO RR, RW, WR, WW conflicts, in that order, 0-10) and the CSR_EVT_CTR_WIDTH constant.
REQ-029 The module SHALL instantiate N_EVENTS copies of one sub-module, cci_mpf_csr_event_ctr, a single counter with inc, clr and value.
REQ-030 The CSR manager SHALL build evt_in from the csr_events modport signals; this block SHALL have no MMIO address decode.

Verification
REQ-031 Pulse evt_in[0] for 5 cycles, read idx 0 -> rsp after 2 cycles, data 5, tid echoed.
REQ-032 Preload counter 3 to 2^48-1, one event, read -> data 0.
REQ-033 Read idx 2 with clr while evt_in[2] high, read again next cycle with no event -> first read old value, second read 1.
REQ-034 Reads idx 0,1,2 on 3 consecutive cycles with tids 0x10,0x11,0x12 -> 3 consecutive responses, same order.
REQ-035 Read idx 15 -> data 0, no counter changed.
REQ-036 Issue read, assert reset next cycle -> no rd_rsp_valid; all counters read 0 afterward.
